// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg : shared types and helpers for the data-memory response path |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Wide enough for any word index; unused upper bits stay zero.
  localparam int IDX_W = 30;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [3:0]       mask;
    logic [31:0]      data;
  } store_entry_t;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    return sgn ? {{24{b[7]}}, b} : {24'h000000, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    return sgn ? {{16{h[15]}}, h} : {16'h0000, h};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wbuf_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wbuf_fifo : circular store buffer with parallel entry read-out        |
// | Rev 1.0   : initial release (DEPTH must be a power of two, >= 2)      |
// +----------------------------------------------------------------------+
module wbuf_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  store_entry_t             push_entry,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output store_entry_t             head_entry,
  output store_entry_t             entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0] head_ptr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  store_entry_t  slots_q [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) slots_q[tail_q] <= push_entry;
  end

  assign full       = (count_q == (PW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign head_entry = slots_q[head_q];
  assign entries    = slots_q;
  assign head_ptr   = head_q;
  assign count      = count_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_resp : data array with store buffer, forwarding and lanes   |
// | Rev 1.0       : initial release                                     |
// +----------------------------------------------------------------------+
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  input  logic [2:0]  funct3M,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        Misalign,
  output logic        WbufEmpty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(WBUF_DEPTH);

  logic [AW-1:0] word_idx;
  logic [1:0]    ofs;
  logic          is_b, is_h, is_w, is_signed, listed, misal_raw;
  logic          store_ok, load_act, push, pop, fifo_full, fifo_empty;
  store_entry_t  push_entry, head_entry;
  store_entry_t  entries [WBUF_DEPTH];
  logic [PW-1:0] head_ptr, slot;
  logic [PW:0]   count;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   merged, load_val;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          unused_bits;

  assign word_idx    = Mem_WrAddr[AW+1:2];
  assign ofs         = Mem_WrAddr[1:0];
  assign unused_bits = ^{Mem_WrAddr[31:AW+2], head_entry.index[IDX_W-1:AW]};

  always_comb begin
    is_b      = 1'b0;
    is_h      = 1'b0;
    is_w      = 1'b0;
    is_signed = 1'b0;
    case (funct3M)
      F3_LB:   begin is_b = 1'b1; is_signed = 1'b1; end
      F3_LBU:  is_b = 1'b1;
      F3_LH:   begin is_h = 1'b1; is_signed = 1'b1; end
      F3_LHU:  is_h = 1'b1;
      F3_LW:   is_w = 1'b1;
      default: is_b = 1'b0;
    endcase
  end

  assign listed    = is_b | is_h | is_w;
  assign misal_raw = (is_h & ofs[0]) | (is_w & (ofs != 2'b00));
  assign Misalign  = (MemReadM | MemWriteM) & misal_raw;

  assign store_ok  = reset & MemWriteM & listed & ~misal_raw;
  assign StallM    = store_ok & fifo_full;
  assign push      = store_ok & ~fifo_full;
  // The single array port is reserved whenever MemReadM is high, even if a
  // concurrent store suppresses the load result; otherwise the buffer could
  // never fill and back-pressure would be unreachable.
  assign pop       = reset & ~fifo_empty & ~MemReadM;
  assign load_act  = reset & MemReadM & ~MemWriteM & listed & ~misal_raw;
  assign WbufEmpty = fifo_empty;

  always_comb begin
    push_entry                = '0;
    push_entry.index[AW-1:0]  = word_idx;
    push_entry.mask           = is_w ? 4'b1111 : (is_h ? (4'b0011 << ofs) : (4'b0001 << ofs));
    push_entry.data           = Mem_WrData << {ofs, 3'b000};
  end

  wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_entry (head_entry),
    .entries    (entries),
    .head_ptr   (head_ptr),
    .count      (count)
  );

  always_ff @(posedge clk) begin
    if (pop) begin
      for (int b = 0; b < 4; b++) begin
        if (head_entry.mask[b])
          mem_q[head_entry.index[AW-1:0]][8*b +: 8] <= head_entry.data[8*b +: 8];
      end
    end
  end

  // Walk pending stores oldest to youngest so the newest byte wins.
  always_comb begin
    merged = mem_q[word_idx];
    slot   = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      slot = head_ptr + PW'(k);
      if (((PW+1)'(k) < count) && (entries[slot].index == push_entry.index)) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[slot].mask[b]) merged[8*b +: 8] = entries[slot].data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    byte_sel = merged[{ofs, 3'b000} +: 8];
    half_sel = merged[{ofs[1], 4'b0000} +: 16];
    load_val = '0;
    if (load_act) begin
      if (is_b)      load_val = ext_byte(byte_sel, is_signed);
      else if (is_h) load_val = ext_half(half_sel, is_signed);
      else           load_val = merged;
    end
  end

  assign ReadDataM = load_val;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_mem_resp : directed self-checking bench for data_mem_resp     |
// | Rev 1.0          : initial release                                  |
// +----------------------------------------------------------------------+
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemWriteM, MemReadM;
  logic [31:0] Mem_WrAddr, Mem_WrData;
  logic [2:0]  funct3M;
  logic [31:0] ReadDataM;
  logic        StallM, Misalign, WbufEmpty;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH(256), .WBUF_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .funct3M    (funct3M),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .Misalign   (Misalign),
    .WbufEmpty  (WbufEmpty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    MemWriteM  = we;
    MemReadM   = re;
    funct3M    = f3;
    Mem_WrAddr = a;
    Mem_WrData = d;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, W, 32'h0, 32'h0);
    repeat (n) next_cyc();
  endtask

  // Issues a load and samples the result mid-cycle.
  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    drive(1'b0, 1'b1, f3, a, 32'h0);
    @(negedge clk);
    check(tag, ReadDataM, exp);
    next_cyc();
  endtask

  task automatic store_drain(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, f3, a, d);
    next_cyc();
    idle(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b1, W, 32'h0, 32'h12345678);
    repeat (2) next_cyc();
    @(negedge clk);
    check("rst_wbuf_empty", WbufEmpty, 1);
    check("rst_stall", StallM, 0);
    check("rst_rdata", ReadDataM, 0);
    next_cyc();
    rst_n = 1'b1;
    idle(1);
    @(negedge clk);
    check("post_rst_empty", WbufEmpty, 1);
    next_cyc();

    // Store then immediate load: served from the buffer
    drive(1'b1, 1'b0, W, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("sw10_stall", StallM, 0);
    check("sw10_misalign", Misalign, 0);
    next_cyc();
    drive(1'b0, 1'b1, W, 32'h10, 32'h0);
    @(negedge clk);
    check("fwd_lw10", ReadDataM, 32'hDEADBEEF);
    check("fwd_pending", WbufEmpty, 0);
    next_cyc();
    idle(2);
    @(negedge clk);
    check("drained_empty", WbufEmpty, 1);
    next_cyc();
    load_chk("array_lw10", W, 32'h10, 32'hDEADBEEF);

    // Byte merge over a drained word
    store_drain(W, 32'h20, 32'h11223344);
    drive(1'b1, 1'b0, B, 32'h21, 32'h000000AA);
    next_cyc();
    load_chk("lb21_fwd", B, 32'h21, 32'hFFFFFFAA);
    load_chk("lbu21_fwd", BU, 32'h21, 32'h000000AA);
    load_chk("lw20_fwd", W, 32'h20, 32'h1122AA44);
    load_chk("lh20_fwd", H, 32'h20, 32'hFFFFAA44);
    idle(2);
    load_chk("lw20_array", W, 32'h20, 32'h1122AA44);
    load_chk("lhu20_array", HU, 32'h20, 32'h0000AA44);
    load_chk("lh22_array", H, 32'h22, 32'h00001122);

    // Fill the buffer while the array port is busy
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, W, 32'h40 + 32'(4 * i), 32'hA0000000 + 32'(i));
      @(negedge clk);
      check("fill_stall", StallM, (i == 4) ? 32'd1 : 32'd0);
      check("both_rdata_zero", ReadDataM, 0);
      next_cyc();
    end
    drive(1'b1, 1'b0, W, 32'h50, 32'hA0000004);
    @(negedge clk);
    check("stall_while_draining", StallM, 1);
    next_cyc();
    @(negedge clk);
    check("accept_after_drain", StallM, 0);
    next_cyc();
    idle(5);
    @(negedge clk);
    check("fill_drained_empty", WbufEmpty, 1);
    next_cyc();
    for (int i = 0; i < 5; i++)
      load_chk("fill_readback", W, 32'h40 + 32'(4 * i), 32'hA0000000 + 32'(i));

    // Misaligned and unlisted accesses
    store_drain(W, 32'h00, 32'h80015678);
    drive(1'b1, 1'b0, H, 32'h03, 32'h0000BEEF);
    @(negedge clk);
    check("sh03_misalign", Misalign, 1);
    check("sh03_stall", StallM, 0);
    next_cyc();
    idle(0);
    @(negedge clk);
    check("sh03_dropped", WbufEmpty, 1);
    next_cyc();
    load_chk("lw00_unchanged", W, 32'h00, 32'h80015678);
    load_chk("lh02_sext", H, 32'h02, 32'hFFFF8001);
    drive(1'b0, 1'b1, W, 32'h01, 32'h0);
    @(negedge clk);
    check("lw01_misalign", Misalign, 1);
    check("lw01_rdata", ReadDataM, 0);
    next_cyc();
    load_chk("unlisted_load", 3'b011, 32'h00, 32'h0);
    drive(1'b1, 1'b0, 3'b111, 32'h00, 32'hFFFFFFFF);
    @(negedge clk);
    check("unlisted_store_stall", StallM, 0);
    next_cyc();
    idle(0);
    @(negedge clk);
    check("unlisted_store_dropped", WbufEmpty, 1);
    next_cyc();
    idle(0);
    @(negedge clk);
    check("idle_no_misalign", Misalign, 0);
    next_cyc();

    // Reset discards pending stores but keeps the array
    store_drain(W, 32'h60, 32'h0BADF00D);
    drive(1'b1, 1'b1, W, 32'h60, 32'h12345678);
    next_cyc();
    drive(1'b1, 1'b1, W, 32'h64, 32'h00000009);
    next_cyc();
    drive(1'b0, 1'b1, W, 32'h60, 32'h0);
    @(negedge clk);
    check("pending_fwd_60", ReadDataM, 32'h12345678);
    rst_n = 1'b0;
    #1;
    check("async_rst_empty", WbufEmpty, 1);
    check("async_rst_rdata", ReadDataM, 0);
    next_cyc();
    rst_n = 1'b1;
    load_chk("lw60_pre_store", W, 32'h60, 32'h0BADF00D);

    // Index wrap-around
    drive(1'b1, 1'b0, W, 32'h400, 32'hCAFEF00D);
    next_cyc();
    load_chk("wrap_fwd", W, 32'h000, 32'hCAFEF00D);
    idle(2);
    load_chk("wrap_array", W, 32'h000, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
